// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [4:0] X0_ADDR = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Per-cycle pipeline control action set.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic pipe_en;
    logic flush;
    logic hazflush;
  } act_t;

  localparam act_t ACT_RUN    = 6'b110101;
  localparam act_t ACT_BUBBLE = 6'b000110;
  localparam act_t ACT_SQUASH = 6'b111110;
  localparam act_t ACT_FREEZE = 6'b000001;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear, else increment unless already at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squashes, memory-wait freezes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rd1_en_id,
  input  logic             rd2_en_id,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_ready,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             pipe_en,
  output logic             flush,
  output logic             hazflush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [1:0] bcnt_q, bcnt_d;
  state_t     eff_state;
  logic       lu_hit;
  act_t       act;

  // Load in EX writing a register that decode reads; x0 never hazards.
  assign lu_hit = load_ex && (rd_ex != X0_ADDR) &&
                  ((rd1_en_id && (rs1_id == rd_ex)) ||
                   (rd2_en_id && (rs2_id == rd_ex)));

  // On a ready cycle MEM_WAIT resolves to the state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  // State, bubble counter and return-state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state selection in action priority order.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    bcnt_d  = bcnt_q;
    if (!dmem_ready) begin
      if (state_q != MEM_WAIT) begin
        ret_d   = state_q;
        state_d = MEM_WAIT;
      end
    end else if (branch_taken_ex) begin
      state_d = RUN;
      bcnt_d  = 2'd0;
    end else if (eff_state == LU_STALL) begin
      bcnt_d  = bcnt_q - 2'd1;
      state_d = (bcnt_q == 2'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      if (LU_BUBBLES > 1) begin
        bcnt_d  = 2'(LU_BUBBLES - 1);
        state_d = LU_STALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

  // Mealy action set; reset forces the frozen, non-flushing pattern.
  always_comb begin
    act = ACT_FREEZE;
    if (rst || !dmem_ready) begin
      act = ACT_FREEZE;
    end else if (branch_taken_ex) begin
      act = ACT_SQUASH;
    end else if ((eff_state == LU_STALL) || ((eff_state == RUN) && lu_hit)) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_RUN;
    end
  end

  assign pc_en      = act.pc_en;
  assign ifid_en    = act.ifid_en;
  assign ifid_flush = act.ifid_flush;
  assign pipe_en    = act.pipe_en;
  assign flush      = act.flush;
  assign hazflush   = act.hazflush;
  assign state_o    = rst ? 2'd0 : 2'(state_q);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (!act.pc_en),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (act.ifid_flush),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers (LU_BUBBLES=1/CNT_W=4 and LU_BUBBLES=2/CNT_W=16) on shared stimulus.
module tb_hazard_ctrl;

  localparam logic [5:0] V_RUN    = 6'b110101;
  localparam logic [5:0] V_BUBBLE = 6'b000110;
  localparam logic [5:0] V_SQUASH = 6'b111110;
  localparam logic [5:0] V_FREEZE = 6'b000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       rd1_en_id, rd2_en_id, load_ex, branch_taken_ex, dmem_ready, clr_cnt;

  logic        a_pc_en, a_ifid_en, a_ifid_flush, a_pipe_en, a_flush, a_hazflush;
  logic [3:0]  a_stall_cnt, a_flush_cnt;
  logic [1:0]  a_state;
  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_pipe_en, b_flush, b_hazflush;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic [1:0]  b_state;

  logic [5:0] a_vec, b_vec;
  assign a_vec = {a_pc_en, a_ifid_en, a_ifid_flush, a_pipe_en, a_flush, a_hazflush};
  assign b_vec = {b_pc_en, b_ifid_en, b_ifid_flush, b_pipe_en, b_flush, b_hazflush};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd1_en_id(rd1_en_id), .rd2_en_id(rd2_en_id), .rd_ex(rd_ex), .load_ex(load_ex),
    .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready), .clr_cnt(clr_cnt),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .pipe_en(a_pipe_en),
    .flush(a_flush), .hazflush(a_hazflush), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt), .state_o(a_state)
  );

  hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd1_en_id(rd1_en_id), .rd2_en_id(rd2_en_id), .rd_ex(rd_ex), .load_ex(load_ex),
    .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready), .clr_cnt(clr_cnt),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .pipe_en(b_pipe_en),
    .flush(b_flush), .hazflush(b_hazflush), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt), .state_o(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check both instances' action sets and states in one call.
  task automatic chk_both(input string tag, input logic [5:0] ea, input logic [1:0] sa,
                          input logic [5:0] eb, input logic [1:0] sb);
    chk({tag, ".a_act"}, 32'(a_vec), 32'(ea));
    chk({tag, ".a_st"},  32'(a_state), 32'(sa));
    chk({tag, ".b_act"}, 32'(b_vec), 32'(eb));
    chk({tag, ".b_st"},  32'(b_state), 32'(sb));
  endtask

  task automatic chk_cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
    chk({tag, ".a_stall"}, 32'(a_stall_cnt), 32'(sa));
    chk({tag, ".a_flush"}, 32'(a_flush_cnt), 32'(fa));
    chk({tag, ".b_stall"}, 32'(b_stall_cnt), 32'(sb));
    chk({tag, ".b_flush"}, 32'(b_flush_cnt), 32'(fb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_id = 5'd5; rd1_en_id = 1'b1; rs2_id = 5'd0; rd2_en_id = 1'b0;
    rd_ex = 5'd5; load_ex = 1'b0; branch_taken_ex = 1'b0;
    dmem_ready = 1'b1; clr_cnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk_both("reset", V_FREEZE, 2'd0, V_FREEZE, 2'd0);
    chk_cnt("reset", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk_both("idle", V_RUN, 2'd0, V_RUN, 2'd0);

    // Load-use on rs1: lw x5 in EX, add x6,x5,x1 in decode.
    load_ex = 1'b1;
    #1;
    chk_both("lu1", V_BUBBLE, 2'd0, V_BUBBLE, 2'd0);
    tick();
    load_ex = 1'b0;
    #1;
    chk_both("lu2", V_RUN, 2'd0, V_BUBBLE, 2'd1);
    chk_cnt("lu2", 1, 0, 1, 0);
    tick();
    #1;
    chk_both("lu3", V_RUN, 2'd0, V_RUN, 2'd0);
    chk_cnt("lu3", 1, 0, 2, 0);

    // Load to x0 never hazards; rs2 match with rd2_en_id=0 never hazards.
    load_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    #1;
    chk_both("x0", V_RUN, 2'd0, V_RUN, 2'd0);
    rd_ex = 5'd7; rs2_id = 5'd7; rd2_en_id = 1'b0;
    #1;
    chk_both("rs2off", V_RUN, 2'd0, V_RUN, 2'd0);
    tick();
    idle();
    #1;
    chk_cnt("nohaz", 1, 0, 2, 0);

    // Branch with simultaneous load-use: squash only.
    load_ex = 1'b1; branch_taken_ex = 1'b1;
    #1;
    chk_both("sq", V_SQUASH, 2'd0, V_SQUASH, 2'd0);
    tick();
    idle();
    #1;
    chk_both("sq_after", V_RUN, 2'd0, V_RUN, 2'd0);
    chk_cnt("sq_after", 1, 1, 2, 1);

    // Clear counters.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    #1;
    chk_cnt("clr1", 0, 0, 0, 0);

    // Memory wait for 3 cycles during LU_STALL.
    load_ex = 1'b1;
    tick();
    load_ex = 1'b0; dmem_ready = 1'b0;
    #1;
    chk_both("mw0", V_FREEZE, 2'd0, V_FREEZE, 2'd1);
    tick();
    #1;
    chk_both("mw1", V_FREEZE, 2'd2, V_FREEZE, 2'd2);
    tick();
    tick();
    dmem_ready = 1'b1;
    #1;
    chk_both("mw_exit", V_RUN, 2'd2, V_BUBBLE, 2'd2);
    chk_cnt("mw_exit", 4, 0, 4, 0);
    tick();
    #1;
    chk_both("mw_done", V_RUN, 2'd0, V_RUN, 2'd0);
    chk_cnt("mw_done", 4, 0, 5, 0);

    // Freeze overrides a pending squash; squash taken on first ready cycle.
    branch_taken_ex = 1'b1; dmem_ready = 1'b0;
    #1;
    chk_both("fz_sq0", V_FREEZE, 2'd0, V_FREEZE, 2'd0);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk_both("fz_sq1", V_SQUASH, 2'd2, V_SQUASH, 2'd2);
    tick();
    idle();
    #1;
    chk_both("fz_sq2", V_RUN, 2'd0, V_RUN, 2'd0);
    chk_cnt("fz_sq2", 5, 1, 6, 1);

    // Saturation: 20 stall cycles, then clear.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    load_ex = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    load_ex = 1'b0;
    #1;
    chk_cnt("sat", 15, 0, 20, 0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    #1;
    chk_cnt("clr2", 0, 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of LU_STALL.
    load_ex = 1'b1;
    tick();
    load_ex = 1'b0;
    #1;
    chk("rst_mid.b_st", 32'(b_state), 32'd1);
    rst = 1'b1;
    #1;
    chk_both("rst_mid", V_FREEZE, 2'd0, V_FREEZE, 2'd0);
    chk_cnt("rst_mid", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk_both("rst_rel", V_RUN, 2'd0, V_RUN, 2'd0);
    chk_cnt("rst_rel", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
